// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared types and helpers for the fifo write-port arbiter.
//   arb_state_t : arbiter FSM state (IDLE = no owner, HOLD = burst owner active)
//   STAT_W      : width of each statistics counter
//   ptr_width() : bits needed to index N_REQ requesters (never less than 1)
package fifo_arb_pkg;

  localparam int STAT_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  function automatic int ptr_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
// Purely combinational rotating priority encoder. Scans req starting at ptr,
// then ptr+1, ... wrapping at N_REQ, and reports the first set bit.
// Ports:
//   req   in  N_REQ  request vector
//   ptr   in  PTR_W  index scanned first
//   valid out 1      some request is set
//   idx   out PTR_W  index of the winning request (0 when !valid)
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] idx
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest hit overwrites
  // the others, giving priority to the requester closest to ptr.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = (int'(ptr) + off) % N_REQ;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Shares the single write port of a fifo between N_REQ producers with
// round-robin selection and an optional burst hold of up to BURST_LEN words.
// Grants are combinational (zero latency); the fifo captures the word on the
// next rising edge. No write is ever issued while fifo_full is high.
// Ports:
//   clk        in  1          system clock, rising edge
//   rst        in  1          synchronous active-high reset
//   req        in  N_REQ      per-requester word available
//   req_data   in  N_REQ*D_W  requester i word at [i*D_W +: D_W]
//   gnt        out N_REQ      one-hot accept of a requester's word
//   fifo_full  in  1          fifo full flag
//   fifo_write out 1          fifo write strobe
//   fifo_data  out D_W        fifo data_in
// Optional (macro FIFO_WR_ARB_STATS_EN):
//   grant_cnt  out N_REQ*16   saturating per-requester grant counters
//   stall_cnt  out 16         saturating count of cycles with |req && fifo_full
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int D_W       = 8,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*D_W-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  input  logic               fifo_full,
  output logic               fifo_write,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [D_W-1:0]     fifo_data,
  output logic [N_REQ*STAT_W-1:0] grant_cnt,
  output logic [STAT_W-1:0]  stall_cnt
`else
  output logic [D_W-1:0]     fifo_data
`endif
);

  localparam int PTR_W = ptr_width(N_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  arb_state_t       state, state_d;
  logic [PTR_W-1:0] owner, owner_d;
  logic [PTR_W-1:0] rr_ptr, ptr_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic             idle_valid, rel_valid;
  logic [PTR_W-1:0] idle_idx, rel_idx, rel_ptr;
  logic             grant_any;
  logic [PTR_W-1:0] grant_idx;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == N_REQ - 1) return '0;
    return p + 1'b1;
  endfunction

  // Pointer used when the current owner releases: the owner is scanned last.
  assign rel_ptr = wrap_inc(owner);

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick_idle (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (idle_valid),
    .idx   (idle_idx)
  );

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick_rel (
    .req   (req),
    .ptr   (rel_ptr),
    .valid (rel_valid),
    .idx   (rel_idx)
  );

  // Grant decision and next state. Reset and fifo_full both suppress any
  // grant and leave every register at its current value.
  always_comb begin
    state_d   = state;
    owner_d   = owner;
    ptr_d     = rr_ptr;
    cnt_d     = cnt;
    grant_any = 1'b0;
    grant_idx = '0;
    if (!rst && !fifo_full) begin
      case (state)
        IDLE: begin
          if (idle_valid) begin
            grant_any = 1'b1;
            grant_idx = idle_idx;
            if (BURST_LEN == 1) begin
              ptr_d = wrap_inc(idle_idx);
            end else begin
              state_d = HOLD;
              owner_d = idle_idx;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (req[owner] && (cnt < CNT_W'(BURST_LEN))) begin
            grant_any = 1'b1;
            grant_idx = owner;
            cnt_d     = cnt + 1'b1;
          end else begin
            ptr_d = rel_ptr;
            if (rel_valid) begin
              grant_any = 1'b1;
              grant_idx = rel_idx;
              owner_d   = rel_idx;
              cnt_d     = CNT_W'(1);
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign gnt        = grant_any ? (N_REQ'(1) << grant_idx) : '0;
  assign fifo_write = grant_any;
  assign fifo_data  = grant_any ? req_data[int'(grant_idx)*D_W +: D_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_d;
      owner  <= owner_d;
      rr_ptr <= ptr_d;
      cnt    <= cnt_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  // Saturating statistics; they never wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i] && (grant_cnt[i*STAT_W +: STAT_W] != {STAT_W{1'b1}}))
          grant_cnt[i*STAT_W +: STAT_W] <= grant_cnt[i*STAT_W +: STAT_W] + 1'b1;
      end
      if ((|req) && fifo_full && (stall_cnt != {STAT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [3:0]  req_a, req_b;
  logic [31:0] data_a, data_b;
  logic        full_a, full_b;
  wire  [3:0]  gnt_a, gnt_b;
  wire         wr_a, wr_b;
  wire  [7:0]  fd_a, fd_b;
`ifdef FIFO_WR_ARB_STATS_EN
  wire  [63:0] gc_a, gc_b;
  wire  [15:0] sc_a, sc_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state per instance: 0 = BURST_LEN 4, 1 = BURST_LEN 1.
  int m_bl[2]    = '{4, 1};
  int m_owner[2] = '{-1, -1};
  int m_cnt[2]   = '{0, 0};
  int m_ptr[2]   = '{0, 0};

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(4), .D_W(8), .BURST_LEN(4)) dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .req        (req_a),
    .req_data   (data_a),
    .gnt        (gnt_a),
    .fifo_full  (full_a),
    .fifo_write (wr_a),
`ifdef FIFO_WR_ARB_STATS_EN
    .fifo_data  (fd_a),
    .grant_cnt  (gc_a),
    .stall_cnt  (sc_a)
`else
    .fifo_data  (fd_a)
`endif
  );

  fifo_wr_arbiter #(.N_REQ(4), .D_W(8), .BURST_LEN(1)) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .req        (req_b),
    .req_data   (data_b),
    .gnt        (gnt_b),
    .fifo_full  (full_b),
    .fifo_write (wr_b),
`ifdef FIFO_WR_ARB_STATS_EN
    .fifo_data  (fd_b),
    .grant_cnt  (gc_b),
    .stall_cnt  (sc_b)
`else
    .fifo_data  (fd_b)
`endif
  );

  // Expected grant for one cycle; advances the reference across the edge.
  function automatic logic [3:0] model_step(int k, logic [3:0] r, logic f, logic rs);
    logic [3:0] eg;
    int w;
    eg = 4'b0000;
    if (rs) begin
      m_owner[k] = -1; m_cnt[k] = 0; m_ptr[k] = 0;
      return eg;
    end
    if (f) return eg;
    if (m_owner[k] >= 0 && r[m_owner[k]] && m_cnt[k] < m_bl[k]) begin
      eg[m_owner[k]] = 1'b1;
      m_cnt[k]++;
      return eg;
    end
    if (m_owner[k] >= 0) begin
      m_ptr[k] = (m_owner[k] + 1) % 4;
      m_owner[k] = -1;
    end
    w = -1;
    for (int j = 0; j < 4; j++)
      if (w < 0 && r[(m_ptr[k] + j) % 4]) w = (m_ptr[k] + j) % 4;
    if (w >= 0) begin
      eg[w] = 1'b1;
      if (m_bl[k] == 1) m_ptr[k] = (w + 1) % 4;
      else begin m_owner[k] = w; m_cnt[k] = 1; end
    end
    return eg;
  endfunction

  function automatic logic [7:0] word_of(logic [31:0] d, logic [3:0] g);
    for (int j = 0; j < 4; j++) if (g[j]) return d[j*8 +: 8];
    return 8'h00;
  endfunction

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b1; req_a = 4'b0; full_a = 1'b0;
    #1 void'(model_step(0, req_a, full_a, 1'b1));
    @(posedge clk);
    #1 rst_a = 1'b0;
  endtask

  task automatic reset_b();
    @(negedge clk);
    rst_b = 1'b1; req_b = 4'b0; full_b = 1'b0;
    #1 void'(model_step(1, req_b, full_b, 1'b1));
    @(posedge clk);
    #1 rst_b = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] ea, eb;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rst_a = (c < 2); rst_b = (c < 2);
      req_a = 4'b1111; req_b = 4'b1111;
      data_a = $urandom; data_b = $urandom;
      full_a = 1'b0; full_b = 1'b0;
      #1;
      ea = model_step(0, req_a, full_a, rst_a);
      eb = model_step(1, req_b, full_b, rst_b);
      n_cmp++;
      if (gnt_a !== ea || wr_a !== |ea || gnt_b !== eb || wr_b !== |eb) begin
        n_bad++;
        $display("[TB] FAIL reset cyc %0d: got a=%b/%b b=%b/%b want a=%b b=%b",
                 c, gnt_a, wr_a, gnt_b, wr_b, ea, eb);
      end
      n_cmp++;
      if (c == 2 && (gnt_a !== 4'b0001 || gnt_b !== 4'b0001 || fd_a !== data_a[7:0])) begin
        n_bad++;
        $display("[TB] FAIL first_grant: got a=%b b=%b data=%h want 0001 data=%h",
                 gnt_a, gnt_b, fd_a, data_a[7:0]);
      end else if (c < 2 && (gnt_a !== 4'b0000 || wr_a !== 1'b0 || fd_a !== 8'h00)) begin
        n_bad++;
        $display("[TB] FAIL reset_gate cyc %0d: got gnt=%b wr=%b data=%h want 0", c, gnt_a, wr_a, fd_a);
      end
    end
  endtask

  task automatic test_burst_rotation();
    logic [3:0] eg;
    reset_a();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      req_a = 4'b1111; data_a = $urandom; full_a = 1'b0;
      #1;
      eg = model_step(0, req_a, full_a, rst_a);
      n_cmp++;
      if (gnt_a !== eg || gnt_a !== (4'b0001 << (c / 4)) || wr_a !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL burst_order cyc %0d: got gnt=%b wr=%b want %b", c, gnt_a, wr_a, eg);
      end
      n_cmp++;
      if (fd_a !== word_of(data_a, eg)) begin
        n_bad++;
        $display("[TB] FAIL burst_data cyc %0d: got %h want %h", c, fd_a, word_of(data_a, eg));
      end
    end
  endtask

  task automatic test_alternate();
    logic [3:0] eg;
    reset_b();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_b = 4'b0101; data_b = $urandom; full_b = 1'b0;
      #1;
      eg = model_step(1, req_b, full_b, rst_b);
      n_cmp++;
      if (gnt_b !== eg || gnt_b !== ((c % 2 == 0) ? 4'b0001 : 4'b0100)) begin
        n_bad++;
        $display("[TB] FAIL alternate cyc %0d: got %b want %b", c, gnt_b, eg);
      end
      n_cmp++;
      if (fd_b !== word_of(data_b, eg)) begin
        n_bad++;
        $display("[TB] FAIL alternate_data cyc %0d: got %h want %h", c, fd_b, word_of(data_b, eg));
      end
    end
  endtask

  task automatic test_full_stall();
    logic [3:0] eg;
    logic [3:0] exp_g[9] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                             4'b0010, 4'b0010, 4'b0100, 4'b0100};
    reset_a();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      req_a  = (c < 2) ? 4'b0010 : 4'b1111;
      full_a = (c >= 2 && c < 5);
      data_a = $urandom;
      #1;
      eg = model_step(0, req_a, full_a, rst_a);
      n_cmp++;
      if (gnt_a !== eg || gnt_a !== exp_g[c] || wr_a !== |exp_g[c]) begin
        n_bad++;
        $display("[TB] FAIL full_stall cyc %0d: got gnt=%b wr=%b want %b", c, gnt_a, wr_a, exp_g[c]);
      end
    end
  endtask

  task automatic test_drop();
    logic [3:0] eg;
    logic [3:0] exp_g[3] = '{4'b0001, 4'b0001, 4'b1000};
    reset_a();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_a = (c < 2) ? 4'b1001 : 4'b1000;
      full_a = 1'b0; data_a = $urandom;
      #1;
      eg = model_step(0, req_a, full_a, rst_a);
      n_cmp++;
      if (gnt_a !== eg || gnt_a !== exp_g[c]) begin
        n_bad++;
        $display("[TB] FAIL drop cyc %0d: got %b want %b", c, gnt_a, exp_g[c]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] ea, eb;
    reset_a();
    reset_b();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      req_a = 4'($urandom); req_b = 4'($urandom);
      data_a = $urandom; data_b = $urandom;
      full_a = ($urandom_range(0, 3) == 0);
      full_b = ($urandom_range(0, 3) == 0);
      #1;
      ea = model_step(0, req_a, full_a, rst_a);
      eb = model_step(1, req_b, full_b, rst_b);
      n_cmp++;
      if (gnt_a !== ea || wr_a !== |ea || (|ea && fd_a !== word_of(data_a, ea))) begin
        n_bad++;
        $display("[TB] FAIL random_a cyc %0d: got gnt=%b data=%h want %b/%h",
                 c, gnt_a, fd_a, ea, word_of(data_a, ea));
      end
      n_cmp++;
      if (gnt_b !== eb || wr_b !== |eb || (|eb && fd_b !== word_of(data_b, eb))) begin
        n_bad++;
        $display("[TB] FAIL random_b cyc %0d: got gnt=%b data=%h want %b/%h",
                 c, gnt_b, fd_b, eb, word_of(data_b, eb));
      end
      n_cmp++;
      if (!$onehot0(gnt_a) || !$onehot0(gnt_b) || (wr_a && full_a) || (wr_b && full_b)) begin
        n_bad++;
        $display("[TB] FAIL invariant cyc %0d: gnt_a=%b full_a=%b gnt_b=%b full_b=%b",
                 c, gnt_a, full_a, gnt_b, full_b);
      end
    end
  endtask

  task automatic test_end_to_end();
    int q[$];
    int sent[3] = '{0, 0, 0};
    int got[3]  = '{0, 0, 0};
    int cyc = 0;
    int v, p, s;
    logic [3:0] eg;
    reset_a();
    while ((got[0] < 30 || got[1] < 30 || got[2] < 30) && cyc < 3000) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        req_a[j] = (sent[j] < 30);
        data_a[j*8 +: 8] = 8'(j * 64 + sent[j]);
      end
      req_a[3] = 1'b0; data_a[31:24] = 8'h00;
      full_a = (q.size() == 16);
      #1;
      eg = model_step(0, req_a, full_a, rst_a);
      n_cmp++;
      if (gnt_a !== eg || wr_a !== |eg || (wr_a && full_a)) begin
        n_bad++;
        $display("[TB] FAIL e2e_grant cyc %0d: got gnt=%b wr=%b full=%b want %b",
                 cyc, gnt_a, wr_a, full_a, eg);
      end
      if ($urandom_range(0, 2) == 0 && q.size() > 0) begin
        v = q.pop_front();
        p = v / 64; s = v % 64;
        n_cmp++;
        if (p > 2 || s != got[(p > 2) ? 0 : p]) begin
          n_bad++;
          $display("[TB] FAIL e2e_order: got word %h want producer<3 seq match", v);
        end else got[p]++;
      end
      if (wr_a && !full_a) q.push_back(int'(fd_a));
      for (int j = 0; j < 3; j++) if (gnt_a[j]) sent[j]++;
      cyc++;
    end
    n_cmp++;
    if (cyc >= 3000 || q.size() != 0 || got[0] != 30 || got[1] != 30 || got[2] != 30) begin
      n_bad++;
      $display("[TB] FAIL e2e_complete: got %0d/%0d/%0d left %0d cyc %0d want 30/30/30",
               got[0], got[1], got[2], q.size(), cyc);
    end
    req_a = 4'b0000;
`ifdef FIFO_WR_ARB_STATS_EN
    @(posedge clk);
    #1;
    n_cmp++;
    if (int'(gc_a[15:0]) + int'(gc_a[31:16]) + int'(gc_a[47:32]) + int'(gc_a[63:48]) != 90 ||
        sc_a == 16'h0000) begin
      n_bad++;
      $display("[TB] FAIL stats: got grants %h stall %0d want total 90 stall>0", gc_a, sc_a);
    end
`endif
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    req_a = 4'b0; req_b = 4'b0;
    data_a = 32'h0; data_b = 32'h0;
    full_a = 1'b0; full_b = 1'b0;
    test_reset();
    test_burst_rotation();
    test_alternate();
    test_full_stall();
    test_drop();
    test_random();
    test_end_to_end();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
